// File: rtl/pwm_pkg.sv
// +-----------------------------------------------------------------+
// | pwm_pkg - shared constants and helpers for the pwm_multi block  |
// | Rev 1.0                                                         |
// +-----------------------------------------------------------------+
`default_nettype none

package pwm_pkg;

  localparam logic MODE_EDGE   = 1'b0;
  localparam logic MODE_CENTRE = 1'b1;

  localparam int unsigned MAX_CNT_W = 32;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  // Periods of 0 and 1 cannot form a waveform, so they run as 2.
  function automatic logic [MAX_CNT_W-1:0] clamp_period(input logic [MAX_CNT_W-1:0] p);
    return (p < 32'd2) ? 32'd2 : p;
  endfunction

endpackage

`default_nettype wire

// File: rtl/pwm_cmp.sv
// +-----------------------------------------------------------------+
// | pwm_cmp - one channel duty compare with registered, invertible  |
// | output. Rev 1.0                                                 |
// +-----------------------------------------------------------------+
`default_nettype none

module pwm_cmp #(
  parameter int   CNT_W = 16,
  parameter logic INV   = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic [CNT_W-1:0] cnt_i,
  input  logic [CNT_W-1:0] duty_i,
  output logic             pwm_o
);

  logic pwm_q;
  logic pwm_d;

  always_comb begin
    pwm_d = INV;
    if (en_i) begin
      pwm_d = (cnt_i < duty_i) ^ INV;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pwm_q <= INV;
    end else begin
      pwm_q <= pwm_d;
    end
  end

  assign pwm_o = pwm_q;

endmodule

`default_nettype wire

// File: rtl/pwm_multi.sv
// +-----------------------------------------------------------------+
// | pwm_multi - N-channel PWM with shared counter, edge/centre modes|
// | and double-buffered updates at the period boundary. Rev 1.0     |
// +-----------------------------------------------------------------+
`default_nettype none

module pwm_multi
  import pwm_pkg::*;
#(
  parameter int              N_CH       = 4,
  parameter int              CNT_W      = 16,
  parameter int              DEF_PERIOD = 10000,
  parameter logic [N_CH-1:0] INV_MASK   = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en_i,
  input  logic                  mode_i,
  input  logic [CNT_W-1:0]      period_i,
  input  logic [N_CH*CNT_W-1:0] duty_i,
  input  logic                  upd_i,
  output logic                  upd_pending_o,
  output logic                  prd_start_o,
  output logic [N_CH-1:0]       pwm_o
);

  localparam logic [CNT_W-1:0] DEF_P = CNT_W'(DEF_PERIOD);

  logic [CNT_W-1:0]      cnt_q,       cnt_d;
  dir_e                  dir_q,       dir_d;
  logic                  mode_q,      mode_d;
  logic [CNT_W-1:0]      period_q,    period_d;
  logic [N_CH*CNT_W-1:0] duty_q,      duty_d;
  logic                  sh_mode_q,   sh_mode_d;
  logic [CNT_W-1:0]      sh_period_q, sh_period_d;
  logic [N_CH*CNT_W-1:0] sh_duty_q,   sh_duty_d;
  logic                  pend_q,      pend_d;
  logic                  prd_q,       prd_d;

  logic [CNT_W-1:0] peff;
  logic [CNT_W-1:0] pm1;
  logic             boundary;
  logic             apply_now;

  assign peff = CNT_W'(clamp_period(MAX_CNT_W'(period_q)));
  assign pm1  = peff - CNT_W'(1);

  // Edge periods end on the top count; centre periods end on the second 0 of the down slope.
  assign boundary  = en_i && ((mode_q == MODE_EDGE) ? (cnt_q == pm1)
                                                    : ((cnt_q == '0) && (dir_q == DIR_DOWN)));
  assign apply_now = !en_i || boundary;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      dir_q       <= DIR_UP;
      mode_q      <= MODE_EDGE;
      period_q    <= DEF_P;
      duty_q      <= '0;
      sh_mode_q   <= MODE_EDGE;
      sh_period_q <= DEF_P;
      sh_duty_q   <= '0;
      pend_q      <= 1'b0;
      prd_q       <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      dir_q       <= dir_d;
      mode_q      <= mode_d;
      period_q    <= period_d;
      duty_q      <= duty_d;
      sh_mode_q   <= sh_mode_d;
      sh_period_q <= sh_period_d;
      sh_duty_q   <= sh_duty_d;
      pend_q      <= pend_d;
      prd_q       <= prd_d;
    end
  end

  // Counter and direction; the top endpoint is held by turning without stepping.
  always_comb begin
    cnt_d = cnt_q;
    dir_d = dir_q;
    if (apply_now) begin
      cnt_d = '0;
      dir_d = DIR_UP;
    end else if (mode_q == MODE_EDGE) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else if (dir_q == DIR_UP) begin
      if (cnt_q == pm1) begin
        dir_d = DIR_DOWN;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_comb begin
    mode_d      = mode_q;
    period_d    = period_q;
    duty_d      = duty_q;
    sh_mode_d   = sh_mode_q;
    sh_period_d = sh_period_q;
    sh_duty_d   = sh_duty_q;
    pend_d      = pend_q;
    if (apply_now) begin
      if (upd_i) begin
        mode_d      = mode_i;
        period_d    = period_i;
        duty_d      = duty_i;
        sh_mode_d   = mode_i;
        sh_period_d = period_i;
        sh_duty_d   = duty_i;
        pend_d      = 1'b0;
      end else if (pend_q) begin
        mode_d   = sh_mode_q;
        period_d = sh_period_q;
        duty_d   = sh_duty_q;
        pend_d   = 1'b0;
      end
    end else if (upd_i) begin
      sh_mode_d   = mode_i;
      sh_period_d = period_i;
      sh_duty_d   = duty_i;
      pend_d      = 1'b1;
    end
  end

  always_comb begin
    prd_d = en_i && (cnt_q == '0) && (dir_q == DIR_UP);
  end

  assign upd_pending_o = pend_q;
  assign prd_start_o   = prd_q;

  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    pwm_cmp #(
      .CNT_W (CNT_W),
      .INV   (INV_MASK[k])
    ) u_cmp (
      .clk    (clk),
      .rst_n  (rst_n),
      .en_i   (en_i),
      .cnt_i  (cnt_q),
      .duty_i (duty_q[k*CNT_W +: CNT_W]),
      .pwm_o  (pwm_o[k])
    );
  end

endmodule

`default_nettype wire

// File: tb/tb_pwm_multi.sv
// +-----------------------------------------------------------------+
// | tb_pwm_multi - directed vector bench for pwm_multi              |
// | Rev 1.0                                                         |
// +-----------------------------------------------------------------+
`default_nettype none

module tb_pwm_multi;

  localparam int N_CH  = 4;
  localparam int CNT_W = 16;
  localparam int DEF_P = 20;

  logic                  clk    = 1'b0;
  logic                  rst_n  = 1'b0;
  logic                  en     = 1'b0;
  logic                  mode   = 1'b0;
  logic                  upd    = 1'b0;
  logic [CNT_W-1:0]      period = 16'd10;
  logic [N_CH*CNT_W-1:0] duty   = '0;

  logic            pend0, pend1, ps0, ps1;
  logic [N_CH-1:0] pwm0, pwm1;

  int n_vec = 0;
  int n_err = 0;

  int m_len, m_inv1, m_pend, m_pat;
  int m_hi[4];

  always #5 clk = ~clk;

  pwm_multi #(.N_CH(N_CH), .CNT_W(CNT_W), .DEF_PERIOD(DEF_P), .INV_MASK(4'b0000)) dut0 (
    .clk(clk), .rst_n(rst_n), .en_i(en), .mode_i(mode), .period_i(period),
    .duty_i(duty), .upd_i(upd), .upd_pending_o(pend0), .prd_start_o(ps0), .pwm_o(pwm0)
  );

  pwm_multi #(.N_CH(N_CH), .CNT_W(CNT_W), .DEF_PERIOD(DEF_P), .INV_MASK(4'b0010)) dut1 (
    .clk(clk), .rst_n(rst_n), .en_i(en), .mode_i(mode), .period_i(period),
    .duty_i(duty), .upd_i(upd), .upd_pending_o(pend1), .prd_start_o(ps1), .pwm_o(pwm1)
  );

  typedef struct {
    logic             m;
    logic [15:0]      p;
    logic [3:0][15:0] d;
    int               len;
    logic [3:0][15:0] hi;
    int               inv1;
  } vec_t;

  vec_t tbl[8];

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic wait_start();
    int guard;
    guard = 0;
    while (ps0 !== 1'b1 && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    if (ps0 !== 1'b1) begin
      n_vec++;
      n_err++;
      $display("FAIL prd_start_timeout: got 0, expected 1");
    end
  endtask

  // Counts one full period starting at a prd_start sample; optionally strobes upd at sample upd_at.
  task automatic measure(input int upd_at);
    int idx;
    m_inv1 = 0; m_pend = 0; m_pat = 0;
    for (int k = 0; k < 4; k++) m_hi[k] = 0;
    wait_start();
    idx = 0;
    do begin
      for (int k = 0; k < 4; k++) if (pwm0[k]) m_hi[k]++;
      if (pwm1[1]) m_inv1++;
      if (pend0) m_pend++;
      if (idx < 20 && pwm0[0]) m_pat = m_pat | (1 << idx);
      upd = (idx == upd_at);
      @(negedge clk);
      idx++;
    end while (ps0 !== 1'b1 && idx < 300);
    upd = 1'b0;
    m_len = idx;
  endtask

  task automatic apply_cfg(input logic m, input logic [15:0] p, input logic [63:0] d);
    en     = 1'b0;
    mode   = m;
    period = p;
    duty   = d;
    upd    = 1'b1;
    @(negedge clk);
    upd = 1'b0;
    @(negedge clk);
  endtask

  function automatic vec_t mk(input logic m, input int p, input logic [63:0] d,
                              input int len, input logic [63:0] hi, input int inv1);
    vec_t v;
    v.m = m; v.p = 16'(p); v.d = d; v.len = len; v.hi = hi; v.inv1 = inv1;
    return v;
  endfunction

  initial begin
    //           mode P   duties ch3..ch0                       len highs ch3..ch0                     inv1
    tbl[0] = mk(1'b0, 10, {16'd15, 16'd10, 16'd3, 16'd0}, 10, {16'd10, 16'd10, 16'd3, 16'd0},  7);
    tbl[1] = mk(1'b1, 10, {16'd3,  16'd3,  16'd3, 16'd3}, 20, {16'd6,  16'd6,  16'd6, 16'd6}, 14);
    tbl[2] = mk(1'b0,  0, {16'd5,  16'd2,  16'd1, 16'd0},  2, {16'd2,  16'd2,  16'd1, 16'd0},  1);
    tbl[3] = mk(1'b0,  1, {16'd3,  16'd1,  16'd1, 16'd0},  2, {16'd2,  16'd1,  16'd1, 16'd0},  1);
    tbl[4] = mk(1'b1,  2, {16'd3,  16'd2,  16'd1, 16'd0},  4, {16'd4,  16'd4,  16'd2, 16'd0},  2);
    tbl[5] = mk(1'b1,  5, {16'd5,  16'd4,  16'd1, 16'd0}, 10, {16'd10, 16'd8,  16'd2, 16'd0},  8);
    tbl[6] = mk(1'b0,  7, {16'd7,  16'd6,  16'd1, 16'd0},  7, {16'd7,  16'd6,  16'd1, 16'd0},  6);
    tbl[7] = mk(1'b1,  0, {16'd2,  16'd2,  16'd1, 16'd0},  4, {16'd4,  16'd4,  16'd2, 16'd0},  2);

    // Reset state
    @(negedge clk);
    @(negedge clk);
    check("rst_pwm0", int'(pwm0), 0);
    check("rst_pwm1", int'(pwm1), 2);
    check("rst_pending", int'(pend0), 0);
    check("rst_prd_start", int'(ps0), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Table vectors: configure while disabled, enable, measure one period
    for (int i = 0; i < 8; i++) begin
      apply_cfg(tbl[i].m, tbl[i].p, tbl[i].d);
      en = 1'b1;
      measure(-1);
      check($sformatf("v%0d_len", i), m_len, tbl[i].len);
      for (int k = 0; k < 4; k++)
        check($sformatf("v%0d_hi_ch%0d", i, k), m_hi[k], int'(tbl[i].hi[k]));
      check($sformatf("v%0d_inv_ch1", i), m_inv1, tbl[i].inv1);
    end

    // Centre P=10 duty 3: high run straddles the period start
    apply_cfg(1'b1, 16'd10, {4{16'd3}});
    en = 1'b1;
    measure(-1);
    check("centre_pattern", m_pat, 32'h000E0007);

    // Buffered update at cnt=4: duty 3 -> 7
    apply_cfg(1'b0, 16'd10, {4{16'd3}});
    en = 1'b1;
    measure(-1);
    duty = {4{16'd7}};
    measure(3);
    check("upd_cur_len", m_len, 10);
    check("upd_cur_hi", m_hi[0], 3);
    check("upd_pending_cycles", m_pend, 5);
    measure(-1);
    check("upd_next_hi", m_hi[0], 7);
    check("upd_next_pending", m_pend, 0);

    // Update on the boundary cycle: P 10 -> 5 applies directly
    period = 16'd5;
    measure(8);
    check("bnd_cur_len", m_len, 10);
    check("bnd_cur_pending", m_pend, 0);
    measure(-1);
    check("bnd_next_len", m_len, 5);
    check("bnd_next_pending", m_pend, 0);
    check("bnd_next_hi_sat", m_hi[0], 5);

    // Reset at cnt=6 with an update pending
    apply_cfg(1'b0, 16'd10, {4{16'd3}});
    en = 1'b1;
    wait_start();
    @(negedge clk);
    @(negedge clk);
    period = 16'd4;
    upd    = 1'b1;
    @(negedge clk);
    upd = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("pend_before_rst", int'(pend0), 1);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_pwm0", int'(pwm0), 0);
    check("midrst_pwm1", int'(pwm1), 2);
    check("midrst_pending", int'(pend0), 0);
    check("midrst_prd_start", int'(ps0), 0);
    rst_n = 1'b1;
    measure(-1);
    check("postrst_len", m_len, DEF_P);
    check("postrst_hi_ch2", m_hi[2], 0);
    check("postrst_inv_ch1", m_inv1, DEF_P);
    check("postrst_pending", m_pend, 0);

    // Disable forces inactive levels; re-enable pulses prd_start one cycle later
    en = 1'b0;
    @(negedge clk);
    check("dis_pwm0", int'(pwm0), 0);
    check("dis_pwm1", int'(pwm1), 2);
    check("dis_prd_start", int'(ps0), 0);
    en = 1'b1;
    @(negedge clk);
    check("en_prd_pulse", int'(ps0), 1);
    @(negedge clk);
    check("en_prd_single", int'(ps0), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
